// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op-field layout, size codes, FSM states.
package lsu_pkg;

  localparam int unsigned OP_W        = 4;
  localparam int unsigned OP_STORE    = 3;
  localparam int unsigned OP_UNSIGNED = 2;
  localparam int unsigned SZ_W        = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned ST_W = 3;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  function automatic logic [SZ_W-1:0] op_size(input logic [OP_W-1:0] op);
    return op[SZ_W-1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Big-endian lane extraction (sign/zero extended) and sub-word store merge.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SZ_W-1:0]  size,
  input  logic             uns,
  input  logic [1:0]       off,
  output logic [WIDTH-1:0] load_data_c,
  output logic [WIDTH-1:0] merge_data_c
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane, so the shift is (3 - off) lanes.
  assign byte_sh = {~off, 3'b000};
  assign half_sh = {~off[1], 4'b0000};
  assign byte_v  = word[byte_sh +: 8];
  assign half_v  = word[half_sh +: 16];

  always_comb begin
    load_data_c  = word;
    merge_data_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c  = uns ? WIDTH'(byte_v) : {{(WIDTH-8){byte_v[7]}}, byte_v};
        merge_data_c = (word & ~(WIDTH'(8'hFF) << byte_sh)) | (WIDTH'(wdata[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_data_c  = uns ? WIDTH'(half_v) : {{(WIDTH-16){half_v[15]}}, half_v};
        merge_data_c = (word & ~(WIDTH'(16'hFFFF) << half_sh)) | (WIDTH'(wdata[15:0]) << half_sh);
      end
      default: begin
        load_data_c  = word;
        merge_data_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-wide data memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  logic [ST_W-1:0]   state, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [WIDTH-1:0]  resp_rdata_d, mem_wr_data_d;
  logic [ADDR_W-1:0] mem_rd_addr_d, mem_wr_addr_d;
  logic              bad_c;
  logic [ADDR_W-1:0] aligned_c;
  logic [WIDTH-1:0]  load_data_c, merge_data_c;

  assign req_ready = (state == IDLE);

  // Request admission: reserved size always errors; misalignment traps or is aligned away.
  always_comb begin
    aligned_c = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    bad_c = (op_size(req_op) == SZ_RSVD)
          || ((op_size(req_op) == SZ_HALF) && req_addr[0])
          || ((op_size(req_op) == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    bad_c = (op_size(req_op) == SZ_RSVD);
    if (op_size(req_op) == SZ_HALF) aligned_c[0]   = 1'b0;
    if (op_size(req_op) == SZ_WORD) aligned_c[1:0] = 2'b00;
`endif
  end

  lsu_lane_unit #(.WIDTH(WIDTH)) u_lane (
    .word         (mem_rd_data),
    .wdata        (wdata_q),
    .size         (op_size(op_q)),
    .uns          (op_q[OP_UNSIGNED]),
    .off          (addr_q[1:0]),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d       = state;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr;
    mem_wr_addr_d = mem_wr_addr;
    mem_wr_data_d = mem_wr_data;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = aligned_c;
          wdata_d = req_wdata;
          if (bad_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_op[OP_STORE] && (op_size(req_op) == SZ_WORD)) begin
            state_d       = WR;
            mem_write_d   = 1'b1;
            mem_wr_addr_d = ADDR_W'(aligned_c >> 2);
            mem_wr_data_d = req_wdata;
          end else begin
            state_d       = RD;
            mem_read_d    = 1'b1;
            mem_rd_addr_d = ADDR_W'(aligned_c >> 2);
          end
        end
      end
      RD: state_d = DATA;
      DATA: begin
        if (op_q[OP_STORE]) begin
          state_d       = WR;
          mem_write_d   = 1'b1;
          mem_wr_addr_d = ADDR_W'(addr_q >> 2);
          mem_wr_data_d = merge_data_c;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data_c;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_rd_addr <= mem_rd_addr_d;
      mem_wr_addr <= mem_wr_addr_d;
      mem_wr_data <= mem_wr_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table with a response scoreboard plus back-to-back and reset sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 32;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [31:0] M8_FINAL = 32'h11ABBEEF;
`else
  localparam logic [31:0] M8_FINAL = 32'h11AB1234;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd_cyc;
    logic [31:0] rd_addr;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [OP_W-1:0]   req_op = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WIDTH-1:0]  req_wdata = '0;
  logic              resp_valid;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              mem_write;
  logic              mem_read;
  logic [WIDTH-1:0]  mem_rd_data = '0;

  logic [31:0] mem [0:63];
  vec_t        vt[$];
  vec_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;

  load_store_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Word memory: write commits at the edge, read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_write) mem[mem_wr_addr[5:0]] <= mem_wr_data;
    if (mem_read)  mem_rd_data <= mem[mem_rd_addr[5:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, trace strobes per cycle, and compare the response against the scoreboard.
  task automatic run_req(input vec_t v, input string name);
    vec_t        e;
    int          n;
    bit          got;
    bit          clash;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] rd_a, wr_a, wr_d;
    sb_q.push_back(v);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk({name, "_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; got = 0; clash = 0; rd_cyc = 0; wr_cyc = 0; rd_a = '0; wr_a = '0; wr_d = '0;
    while (n <= 20 && !got) begin
      if (mem_read && mem_write) clash = 1;
      if (mem_read && rd_cyc == 0) begin rd_cyc = n; rd_a = mem_rd_addr; end
      if (mem_write) begin wr_cyc = n; wr_a = mem_wr_addr; wr_d = mem_wr_data; end
      if (resp_valid) got = 1;
      else begin @(negedge clk); n++; end
    end
    e = sb_q.pop_front();
    chk({name, "_resp_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(e.lat));
    chk({name, "_rdata"}, resp_rdata, e.rdata);
    chk({name, "_err"}, 32'(resp_err), 32'(e.err));
    chk({name, "_strobe_clash"}, 32'(clash), 32'd0);
    chk({name, "_rd_cycle"}, 32'(rd_cyc), 32'(e.rd_cyc));
    if (e.rd_cyc != 0) chk({name, "_rd_addr"}, rd_a, e.rd_addr);
    chk({name, "_wr_cycle"}, 32'(wr_cyc), 32'(e.wr_cyc));
    if (e.wr_cyc != 0) begin
      chk({name, "_wr_addr"}, wr_a, e.wr_addr);
      chk({name, "_wr_data"}, wr_d, e.wr_data);
    end
  endtask

  initial begin
    int   n;
    bit   busy_ready;
    bit   activity;
    vec_t lw20;

    // op = {store, unsigned, size}; fields: op, addr, wdata, rdata, err, lat, rd_cyc, rd_addr, wr_cyc, wr_addr, wr_data
    vt.push_back('{4'b1010, 32'h20, 32'h11223344, 32'h0,        1'b0, 2, 0, 32'd0, 1, 32'd8, 32'h11223344});
    vt.push_back('{4'b1010, 32'h14, 32'h00000036, 32'h0,        1'b0, 2, 0, 32'd0, 1, 32'd5, 32'h00000036});
    vt.push_back('{4'b0010, 32'h14, 32'h0,        32'h00000036, 1'b0, 3, 1, 32'd5, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1000, 32'h21, 32'h123456AB, 32'h0,        1'b0, 4, 1, 32'd8, 3, 32'd8, 32'h11AB3344});
    vt.push_back('{4'b0000, 32'h21, 32'h0,        32'hFFFFFFAB, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0100, 32'h21, 32'h0,        32'h000000AB, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0001, 32'h22, 32'h0,        32'h00003344, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0001, 32'h20, 32'h0,        32'h000011AB, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0000, 32'h23, 32'h0,        32'h00000044, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1001, 32'h22, 32'hCAFEBEEF, 32'h0,        1'b0, 4, 1, 32'd8, 3, 32'd8, 32'h11ABBEEF});
    vt.push_back('{4'b0001, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0101, 32'h22, 32'h0,        32'h0000BEEF, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0110, 32'h20, 32'h0,        32'h11ABBEEF, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0011, 32'h14, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1111, 32'h14, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back('{4'b0010, 32'h16, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0001, 32'h21, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1010, 32'h1B, 32'h00000055, 32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1001, 32'h23, 32'h00001234, 32'h0,        1'b1, 1, 0, 32'd0, 0, 32'd0, 32'h0});
`else
    vt.push_back('{4'b0010, 32'h16, 32'h0,        32'h00000036, 1'b0, 3, 1, 32'd5, 0, 32'd0, 32'h0});
    vt.push_back('{4'b0001, 32'h21, 32'h0,        32'h000011AB, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0});
    vt.push_back('{4'b1010, 32'h1B, 32'h00000055, 32'h0,        1'b0, 2, 0, 32'd0, 1, 32'd6, 32'h00000055});
    vt.push_back('{4'b1001, 32'h23, 32'h00001234, 32'h0,        1'b0, 4, 1, 32'd8, 3, 32'd8, 32'h11AB1234});
`endif
    lw20 = '{4'b0010, 32'h20, 32'h0, M8_FINAL, 1'b0, 3, 1, 32'd8, 0, 32'd0, 32'h0};
    vt.push_back(lw20);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {28'h0, resp_valid, resp_err, mem_read, mem_write}, 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_rd_addr", mem_rd_addr, 32'h0);
    chk("rst_wr_addr", mem_wr_addr, 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    rst_n = 1'b1;

    foreach (vt[i]) run_req(vt[i], $sformatf("vec%0d", i));

    // Second request held while a byte store is in flight
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h21; req_wdata = 32'h77;
    chk("b2b_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_op = 4'b0010; req_addr = 32'h20; req_wdata = '0;
    busy_ready = 0; n = 1;
    while (!resp_valid && n < 10) begin busy_ready |= req_ready; @(negedge clk); n++; end
    busy_ready |= req_ready;
    chk("b2b_busy_ready", 32'(busy_ready), 32'd0);
    chk("b2b_sb_latency", 32'(n), 32'd4);
    @(negedge clk);
    chk("b2b_ready_after_resp", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; n = 1;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    chk("b2b_lw_latency", 32'(n), 32'd3);
    chk("b2b_lw_rdata", resp_rdata, {16'h1177, M8_FINAL[15:0]});

    // Reset while a byte store sits in DATA
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h23; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {28'h0, resp_valid, resp_err, mem_read, mem_write}, 32'h0);
    chk("midrst_rd_addr", mem_rd_addr, 32'h0);
    chk("midrst_wr_addr", mem_wr_addr, 32'h0);
    chk("midrst_wr_data", mem_wr_data, 32'h0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    activity = 0;
    repeat (6) begin @(negedge clk); activity |= resp_valid | mem_write; end
    chk("midrst_no_activity", 32'(activity), 32'd0);
    lw20.rdata = {16'h1177, M8_FINAL[15:0]};
    run_req(lw20, "midrst_word_intact");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage placed directly upstream of the word-wide data memory (32-bit data, word-indexed read/write addresses, memwrite/memread strobes). Accepts one load/store request at a time from the execute stage. Drives the memory ports, performs big-endian byte/halfword extraction with sign/zero extension, and performs read-modify-write for sub-word stores. Returns one response per request.

Parameters:
WIDTH, 32, data width; must equal the memory data width.
ADDR_W, 32, byte-address width of requests and memory address ports.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
req_op  in  4  {store, unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 reserved
req_addr  in  ADDR_W  byte address
req_wdata  in  WIDTH  store data, right-justified for sub-word stores
resp_valid  out  1  one-cycle pulse per accepted request
resp_rdata  out  WIDTH  load result; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned access or reserved size
mem_rd_addr  out  ADDR_W  word index (req_addr >> 2)
mem_wr_addr  out  ADDR_W  word index
mem_wr_data  out  WIDTH  word to write
mem_write  out  1  memory commits mem_wr_data at the rising edge where this is high
mem_read  out  1  read strobe
mem_rd_data  in  WIDTH  read word; valid the cycle after the mem_read cycle

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data = 0.
- All outputs are registered. req_ready is decoded from the state register.
- Big-endian lane mapping:
  - byte offset 0 = bits [31:24], 3 = bits [7:0].
  - halfword offset 0 = [31:16], 2 = [15:0].
- States:
  - IDLE: on accept, latch op, addr and wdata.
    - Reserved size or trapped misalignment -> RESP with err=1.
    - Word store -> WR.
    - Any load or sub-word store -> RD.
  - RD: mem_read=1, mem_rd_addr=word index -> DATA.
  - DATA: sample mem_rd_data.
    - Load: extract lane; signed ops sign-extend, unsigned ops zero-extend -> RESP.
    - Sub-word store: merge the low bits of wdata into the selected lane, other lanes unchanged -> WR.
  - WR: mem_write=1 with mem_wr_addr and mem_wr_data -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. There is no response backpressure.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- The next request can be accepted in the cycle after RESP.
- Unsigned bit is ignored for stores. Word loads ignore the unsigned bit.
- mem_read and mem_write are never high together.
- mem_rd_addr and mem_wr_addr hold their last value when the strobes are low.
- req_valid while busy: ignored (req_ready=0). Requesters must hold the request until accepted.
- Reset mid-operation:
  - A write whose mem_write is already high at the reset edge completes at that edge.
  - All later steps are dropped and no response is produced.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: halfword with addr[0]!=0, or word with addr[1:0]!=0, gives err=1 after 1 cycle with no memory strobes.
- Undefined: low address bits are forced to alignment (half: bit0 cleared; word: bits[1:0] cleared), the access proceeds normally, and resp_err is asserted only for reserved size.

Decomposition:
- Package lsu_pkg holds:
  - op field positions
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, RD, DATA, WR, RESP)
- Sub-module lsu_lane_unit (combinational) holds:
  - lane extract with sign/zero extend
  - sub-word merge
- load_store_unit holds the FSM, latches and port registers.

Test Plan:
1. SW addr 0x14, wdata 0x00000036 -> mem_write=1 in cycle 1 with mem_wr_addr=5 and mem_wr_data=0x36; resp_valid in cycle 2 with err=0.
2. LW 0x14 after test 1 -> mem_read in cycle 1 with mem_rd_addr=5; resp_valid in cycle 3 with rdata=0x00000036.
3. Word 8 preloaded to 0x11223344; SB addr 0x21, wdata 0xAB -> read of word 8, then write of 0x11AB3344; resp in cycle 4.
4. Loads from word 8 = 0x11AB3344:
   - LB 0x21 -> 0xFFFFFFAB
   - LBU 0x21 -> 0x000000AB
   - LH 0x22 -> 0x00003344
   - LH 0x20 -> 0x000011AB
5. LW 0x16:
   - with LSU_MISALIGN_TRAP_EN: resp_err=1 in cycle 1, no strobes.
   - without it: reads word 5 and returns 0x36.
   - size 11 -> err in both builds.
6. Back-to-back and reset:
   - Second request held during an SB: req_ready=0 until after RESP, then accepted.
   - rst_n low during DATA of an SB: no mem_write, no resp_valid, all outputs 0 next cycle.
